// File: rtl/my_pkg.sv
// Shared constants and state encoding for the memory initiator.
package my_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int MAX_READ_LATENCY = 4;
    localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_init_state_e;

endpackage

// File: rtl/memory_initiator.sv
// Single-transaction bus initiator driving the memory unit's pins.
// Optional feature: define WRITE_ACK_EN to make writes return a response echoing the written data.
module memory_initiator #(
    parameter int DATA_WIDTH   = my_pkg::DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    import my_pkg::*;

    localparam int LAT_LOAD_INT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_LOAD_INT);

    mem_init_state_e       state_q, state_d;
    logic                  write_q, write_d;
    logic [LAT_CNT_W-1:0]  latCnt_q, latCnt_d;
    logic                  memWe_q, memWe_d;
    logic [DATA_WIDTH-1:0] memWd_q, memWd_d;
    logic [DATA_WIDTH-1:0] memAddr_q, memAddr_d;
    logic                  rspValid_q, rspValid_d;
    logic [DATA_WIDTH-1:0] rspRdata_q, rspRdata_d;

    // The memory address/data registers double as the request latch, so the
    // pins carry the request from the cycle after acceptance onward.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        latCnt_d   = latCnt_q;
        memWe_d    = 1'b0;
        memWd_d    = memWd_q;
        memAddr_d  = memAddr_q;
        rspValid_d = rspValid_q;
        rspRdata_d = rspRdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d   = req_write_i;
                    memAddr_d = req_addr_i;
                    if (req_write_i) begin
                        memWe_d = 1'b1;
                        memWd_d = req_wdata_i;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (write_q) begin
`ifdef WRITE_ACK_EN
                    rspValid_d = 1'b1;
                    rspRdata_d = memWd_q;
                    state_d    = RESP;
`else
                    state_d    = IDLE;
`endif
                end else if (READ_LATENCY == 1) begin
                    rspValid_d = 1'b1;
                    rspRdata_d = mem_rd_i;
                    state_d    = RESP;
                end else begin
                    latCnt_d = LAT_LOAD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (latCnt_q == '0) begin
                    rspValid_d = 1'b1;
                    rspRdata_d = mem_rd_i;
                    state_d    = RESP;
                end else begin
                    latCnt_d = latCnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            latCnt_q   <= '0;
            memWe_q    <= 1'b0;
            memWd_q    <= '0;
            memAddr_q  <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            latCnt_q   <= latCnt_d;
            memWe_q    <= memWe_d;
            memWd_q    <= memWd_d;
            memAddr_q  <= memAddr_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    // Ready is gated by reset so nothing can be accepted while held in reset.
    assign req_ready_o = rst_n && (state_q == IDLE);
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign mem_we_o    = memWe_q;
    assign mem_wd_o    = memWd_q;
    assign mem_addr_o  = memAddr_q;

endmodule

// File: tb/tb_memory_initiator.sv
// Directed bench for memory_initiator: instance A at READ_LATENCY 1, instance B at READ_LATENCY 4.
// Each instance talks to its own small memory model.
module tb_memory_initiator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        aReqValid, aReqReady, aReqWrite, aRspValid, aRspReady, aMemWe;
    logic [31:0] aReqAddr, aReqWdata, aRspRdata, aMemWd, aMemAddr, aMemRd;
    logic        bReqValid, bReqReady, bReqWrite, bRspValid, bRspReady, bMemWe;
    logic [31:0] bReqAddr, bReqWdata, bRspRdata, bMemWd, bMemAddr, bMemRd;

    logic [31:0] memA [0:255];
    logic [31:0] memB [0:255];

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    memory_initiator #(.DATA_WIDTH(32), .READ_LATENCY(1)) dutA (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(aReqValid), .req_ready_o(aReqReady), .req_write_i(aReqWrite),
        .req_addr_i(aReqAddr), .req_wdata_i(aReqWdata),
        .rsp_valid_o(aRspValid), .rsp_ready_i(aRspReady), .rsp_rdata_o(aRspRdata),
        .mem_we_o(aMemWe), .mem_wd_o(aMemWd), .mem_addr_o(aMemAddr), .mem_rd_i(aMemRd)
    );

    memory_initiator #(.DATA_WIDTH(32), .READ_LATENCY(4)) dutB (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(bReqValid), .req_ready_o(bReqReady), .req_write_i(bReqWrite),
        .req_addr_i(bReqAddr), .req_wdata_i(bReqWdata),
        .rsp_valid_o(bRspValid), .rsp_ready_i(bRspReady), .rsp_rdata_o(bRspRdata),
        .mem_we_o(bMemWe), .mem_wd_o(bMemWd), .mem_addr_o(bMemAddr), .mem_rd_i(bMemRd)
    );

    // Synchronous-write, combinational-read memories
    always @(posedge clk) begin
        if (aMemWe) memA[aMemAddr[7:0]] <= aMemWd;
        if (bMemWe) memB[bMemAddr[7:0]] <= bMemWd;
    end
    assign aMemRd = memA[aMemAddr[7:0]];
    assign bMemRd = memB[bMemAddr[7:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] ad, input logic [31:0] wd);
        aReqValid = v;
        aReqWrite = w;
        aReqAddr  = ad;
        aReqWdata = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] b2bData(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0101;
    endfunction

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        aRspReady = 1'b1;
        bReqValid = 1'b0; bReqWrite = 1'b0; bReqAddr = 32'h0; bReqWdata = 32'h0;
        bRspReady = 1'b1;

        #2;
        checkOutput("rst_req_ready_a", 32'(aReqReady), 32'h0);
        checkOutput("rst_req_ready_b", 32'(bReqReady), 32'h0);
        checkOutput("rst_mem_we", 32'(aMemWe), 32'h0);
        checkOutput("rst_rsp_valid", 32'(aRspValid), 32'h0);
        checkOutput("rst_rsp_rdata", aRspRdata, 32'h0);
        checkOutput("rst_mem_addr", aMemAddr, 32'h0);
        checkOutput("rst_mem_wd", aMemWd, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready_a", 32'(aReqReady), 32'h1);
        checkOutput("post_rst_ready_b", 32'(bReqReady), 32'h1);

        // Seed A at 0x30 for the discarded-write check later
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h1111_1111);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
`ifdef WRITE_ACK_EN
        tick();
`endif

        // Write 0xDEADBEEF to 0x4 then read it back at latency 1
        applyStimulus(1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("wr_issue_we", 32'(aMemWe), 32'h1);
        checkOutput("wr_issue_addr", aMemAddr, 32'h4);
        checkOutput("wr_issue_wd", aMemWd, 32'hDEAD_BEEF);
        checkOutput("wr_issue_ready", 32'(aReqReady), 32'h0);
        tick();
        checkOutput("wr_we_one_cycle", 32'(aMemWe), 32'h0);
`ifdef WRITE_ACK_EN
        checkOutput("wr_ack_valid", 32'(aRspValid), 32'h1);
        checkOutput("wr_ack_data", aRspRdata, 32'hDEAD_BEEF);
        checkOutput("wr_ack_ready", 32'(aReqReady), 32'h0);
        tick();
`else
        checkOutput("wr_no_rsp", 32'(aRspValid), 32'h0);
`endif
        checkOutput("wr_ready_again", 32'(aReqReady), 32'h1);

        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rd_issue_addr", aMemAddr, 32'h4);
        checkOutput("rd_issue_we", 32'(aMemWe), 32'h0);
        checkOutput("rd_issue_no_rsp", 32'(aRspValid), 32'h0);
        tick();
        checkOutput("rd_rsp_valid", 32'(aRspValid), 32'h1);
        checkOutput("rd_rsp_data", aRspRdata, 32'hDEAD_BEEF);
        tick();
        checkOutput("rd_rsp_done", 32'(aRspValid), 32'h0);
        checkOutput("rd_ready_again", 32'(aReqReady), 32'h1);

        // Hold off the response for 10 cycles while another request is offered
        aRspReady = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h5555_5555);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp_valid_%0d", i), 32'(aRspValid), 32'h1);
            checkOutput($sformatf("bp_data_%0d", i), aRspRdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("bp_ready_%0d", i), 32'(aReqReady), 32'h0);
            checkOutput($sformatf("bp_we_%0d", i), 32'(aMemWe), 32'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        aRspReady = 1'b1;
        tick();
        checkOutput("bp_release_valid", 32'(aRspValid), 32'h0);
        checkOutput("bp_release_ready", 32'(aReqReady), 32'h1);

        // Back-to-back writes to 0x0..0x7, then read them all back
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i), b2bData(i));
            checkOutput($sformatf("b2b_ready_%0d", i), 32'(aReqReady), 32'h1);
            tick();
            checkOutput($sformatf("b2b_we_%0d", i), 32'(aMemWe), 32'h1);
            checkOutput($sformatf("b2b_addr_%0d", i), aMemAddr, 32'(i));
            checkOutput($sformatf("b2b_wd_%0d", i), aMemWd, b2bData(i));
            checkOutput($sformatf("b2b_busy_%0d", i), 32'(aReqReady), 32'h0);
            tick();
`ifdef WRITE_ACK_EN
            checkOutput($sformatf("b2b_ack_valid_%0d", i), 32'(aRspValid), 32'h1);
            checkOutput($sformatf("b2b_ack_data_%0d", i), aRspRdata, b2bData(i));
            tick();
`endif
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i), 32'h0);
            tick();
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            checkOutput($sformatf("rb_valid_%0d", i), 32'(aRspValid), 32'h1);
            checkOutput($sformatf("rb_data_%0d", i), aRspRdata, b2bData(i));
            tick();
        end

        // Instance B: preload 0x10, then read at latency 4
        bReqValid = 1'b1; bReqWrite = 1'b1; bReqAddr = 32'h10; bReqWdata = 32'h1234_5678;
        tick();
        bReqValid = 1'b0; bReqWrite = 1'b0;
        tick();
`ifdef WRITE_ACK_EN
        tick();
`endif
        checkOutput("lat4_pre_ready", 32'(bReqReady), 32'h1);
        bReqValid = 1'b1; bReqAddr = 32'h10;
        tick();
        bReqValid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("lat4_addr_c%0d", k), bMemAddr, 32'h10);
            checkOutput($sformatf("lat4_we_c%0d", k), 32'(bMemWe), 32'h0);
            checkOutput($sformatf("lat4_norsp_c%0d", k), 32'(bRspValid), 32'h0);
            tick();
        end
        checkOutput("lat4_rsp_valid", 32'(bRspValid), 32'h1);
        checkOutput("lat4_rsp_data", bRspRdata, 32'h1234_5678);
        tick();
        checkOutput("lat4_rsp_done", 32'(bRspValid), 32'h0);

        // Reset while B waits on a read and A is issuing a write to 0x30
        bReqValid = 1'b1; bReqAddr = 32'h10;
        tick();
        bReqValid = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("mid_a_we_before", 32'(aMemWe), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_a_we", 32'(aMemWe), 32'h0);
        checkOutput("mid_a_addr", aMemAddr, 32'h0);
        checkOutput("mid_a_wd", aMemWd, 32'h0);
        checkOutput("mid_b_addr", bMemAddr, 32'h0);
        checkOutput("mid_b_rdata", bRspRdata, 32'h0);
        checkOutput("mid_b_valid", 32'(bRspValid), 32'h0);
        checkOutput("mid_b_ready", 32'(bReqReady), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("rel_b_valid_%0d", i), 32'(bRspValid), 32'h0);
            checkOutput($sformatf("rel_b_ready_%0d", i), 32'(bReqReady), 32'h1);
            checkOutput($sformatf("rel_a_we_%0d", i), 32'(aMemWe), 32'h0);
        end

        // The aborted write must not have reached memory
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("abort_rb_valid", 32'(aRspValid), 32'h1);
        checkOutput("abort_rb_data", aRspRdata, 32'h1111_1111);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
